// File: rtl/core_pkg.sv
// Shared definitions for the memory-side blocks: arbiter FSM states,
// memory access size encoding and the default BUSY timeout.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit 2 marks an unsigned load; bits 1:0 select byte, half or word.
    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is fetch and bit 1 is data. The pointer
// moves on every grant so that a tie goes to whoever was not served last.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_data_q;
    logic prio_data_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch; otherwise the
        // paths that skip an assignment infer a latch.
        gnt_o       = 2'b00;
        prio_data_d = prio_data_q;
        if (en_i) begin
            if (req_i[1] && (!req_i[0] || prio_data_q)) begin
                gnt_o = 2'b10;
            end else if (req_i[0]) begin
                gnt_o = 2'b01;
            end
            if (|req_i) begin
                prio_data_d = gnt_o[0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its _d value from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_data_q <= 1'b0;
        end else begin
            prio_data_q <= prio_data_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one memory port. Only one
// transaction is in flight at a time (IDLE -> BUSY -> DONE), and a wait that
// runs too long completes with an error.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ireq_i,
    input  logic [31:0] iaddr_i,
    output logic        irdy_o,
    output logic [31:0] idata_o,
    input  logic        dreq_i,
    input  logic        dwe_i,
    input  logic [2:0]  dsize_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwd_i,
    output logic        drdy_o,
    output logic [31:0] drdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        gnt_data_q, gnt_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        irdy_q, irdy_d;
    logic        drdy_q, drdy_d;
    logic        err_q, err_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] drdata_q, drdata_d;
    logic [1:0]  gnt;
    logic        timeout_hit;

    rr_arbiter2 u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == ST_IDLE),
        .req_i ({dreq_i, ireq_i}),
        .gnt_o (gnt)
    );

    // The current BUSY cycle is number wait_cnt_q + 1.
    assign timeout_hit = ({24'd0, wait_cnt_q} + 32'd1) >= TIMEOUT;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gnt_data_d = gnt_data_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_size_d = mem_size_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        irdy_d     = 1'b0;
        drdy_d     = 1'b0;
        err_d      = 1'b0;
        idata_d    = idata_q;
        drdata_d   = drdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    state_d    = ST_BUSY;
                    wait_cnt_d = 8'd0;
                    mem_req_d  = 1'b1;
                    gnt_data_d = gnt[1];
                    if (gnt[1]) begin
                        mem_we_d   = dwe_i;
                        mem_size_d = dsize_i;
                        mem_addr_d = daddr_i;
                        mem_wd_d   = dwd_i;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_size_d = SIZE_W;
                        mem_addr_d = iaddr_i;
                        mem_wd_d   = 32'd0;
                    end
                end
            end
            ST_BUSY: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (mem_ready_i || timeout_hit) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    irdy_d    = !gnt_data_q;
                    drdy_d    = gnt_data_q;
                    err_d     = !mem_ready_i;
                    // Ready wins over a timeout in the same cycle.
                    if (!gnt_data_q) begin
                        idata_d = mem_ready_i ? mem_rd_i : 32'd0;
                    end else if (!mem_ready_i) begin
                        drdata_d = 32'd0;
                    end else if (!mem_we_q) begin
                        drdata_d = mem_rd_i;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            gnt_data_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_size_q <= 3'd0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
            irdy_q     <= 1'b0;
            drdy_q     <= 1'b0;
            err_q      <= 1'b0;
            idata_q    <= 32'd0;
            drdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gnt_data_q <= gnt_data_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_size_q <= mem_size_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            irdy_q     <= irdy_d;
            drdy_q     <= drdy_d;
            err_q      <= err_d;
            idata_q    <= idata_d;
            drdata_q   <= drdata_d;
        end
    end

    assign irdy_o     = irdy_q;
    assign idata_o    = idata_q;
    assign drdy_o     = drdy_q;
    assign drdata_o   = drdata_q;
    assign err_o      = err_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_size_o = mem_size_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ireq_i, dreq_i, dwe_i, mem_ready_i;
    logic [31:0] iaddr_i, daddr_i, dwd_i, mem_rd_i;
    logic [2:0]  dsize_i;
    logic        irdy_o, drdy_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] idata_o, drdata_o, mem_addr_o, mem_wd_o;
    logic [2:0]  mem_size_o;

    int checks = 0;
    int errors = 0;

    // Reference model: who was served last, and what each port last returned.
    bit          m_last_data;
    logic [31:0] idata_m, drdata_m;

    mem_arbiter #(.TIMEOUT(255)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ireq_i      (ireq_i),
        .iaddr_i     (iaddr_i),
        .irdy_o      (irdy_o),
        .idata_o     (idata_o),
        .dreq_i      (dreq_i),
        .dwe_i       (dwe_i),
        .dsize_i     (dsize_i),
        .daddr_i     (daddr_i),
        .dwd_i       (dwd_i),
        .drdy_o      (drdy_o),
        .drdata_o    (drdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_size_o  (mem_size_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_irdy"}, 32'(irdy_o), 32'd0);
        check({tag, "_drdy"}, 32'(drdy_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_idata"}, idata_o, idata_m);
        check({tag, "_drdata"}, drdata_o, drdata_m);
    endtask

    task automatic model_reset();
        m_last_data = 1'b1;
        idata_m     = 32'd0;
        drdata_m    = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        ireq_i = 1'b0;
        dreq_i = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        check_quiet("reset");
        check("reset_mem_we", 32'(mem_we_o), 32'd0);
        check("reset_mem_size", 32'(mem_size_o), 32'd0);
        check("reset_mem_addr", mem_addr_o, 32'd0);
        check("reset_mem_wd", mem_wd_o, 32'd0);
    endtask

    // One full transaction. lat is the BUSY cycle (1-based) on which memory
    // answers; 0 means it never answers and the transaction must time out.
    task automatic run_txn(input bit ri, input bit rd, input bit we, input logic [2:0] sz,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] rdv, input int lat);
        bit g_data;
        bit done;
        bit to;
        int n;
        logic [31:0] exp_addr;
        g_data      = rd && (!ri || !m_last_data);
        m_last_data = g_data;
        exp_addr    = g_data ? da : ia;
        to          = (lat == 0);

        @(negedge clk_i);
        ireq_i = ri; iaddr_i = ia;
        dreq_i = rd; dwe_i = we; dsize_i = sz; daddr_i = da; dwd_i = wd;
        @(posedge clk_i);
        @(negedge clk_i);
        check("grant_mem_req", 32'(mem_req_o), 32'd1);
        check("grant_mem_addr", mem_addr_o, exp_addr);
        check("grant_mem_we", 32'(mem_we_o), g_data ? 32'(we) : 32'd0);
        check("grant_mem_size", 32'(mem_size_o), g_data ? 32'(sz) : 32'd2);
        if (g_data) check("grant_mem_wd", mem_wd_o, wd);

        n = 1;
        done = 1'b0;
        while (!done && n <= 300) begin
            mem_ready_i = (n == lat);
            mem_rd_i    = (n == lat) ? rdv : $urandom();
            @(posedge clk_i);
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            if (irdy_o || drdy_o) begin
                done = 1'b1;
            end else begin
                check("busy_mem_req", 32'(mem_req_o), 32'd1);
                check("busy_mem_addr", mem_addr_o, exp_addr);
                n++;
            end
        end
        check("busy_len", 32'(n), to ? 32'd255 : 32'(lat));

        if (to) begin
            if (g_data) drdata_m = 32'd0; else idata_m = 32'd0;
        end else if (!g_data) begin
            idata_m = rdv;
        end else if (!we) begin
            drdata_m = rdv;
        end
        check("done_irdy", 32'(irdy_o), 32'(!g_data));
        check("done_drdy", 32'(drdy_o), 32'(g_data));
        check("done_err", 32'(err_o), 32'(to));
        check("done_mem_req", 32'(mem_req_o), 32'd0);
        check("done_idata", idata_o, idata_m);
        check("done_drdata", drdata_o, drdata_m);

        @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("after_done");
        ireq_i = 1'b0;
        dreq_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        ireq_i = 1'b0; iaddr_i = '0;
        dreq_i = 1'b0; dwe_i = 1'b0; dsize_i = '0; daddr_i = '0; dwd_i = '0;
        mem_ready_i = 1'b0; mem_rd_i = '0;
        repeat (3) @(posedge clk_i);
        do_reset();

        // Single fetch with one-cycle memory.
        run_txn(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h00500093, 1);

        // Simultaneous pairs after reset: fetch, data write, fetch.
        do_reset();
        run_txn(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'h3000, 32'h0, 32'h11111111, 1);
        run_txn(1'b1, 1'b1, 1'b1, 3'b010, 32'h108, 32'h2000, 32'hDEADBEEF, 32'h22222222, 2);
        run_txn(1'b1, 1'b1, 1'b0, 3'b000, 32'h10C, 32'h3004, 32'h0, 32'h33333333, 1);

        // Data read so the timeout below has a non-zero value to clear.
        run_txn(1'b0, 1'b1, 1'b0, 3'b100, 32'h0, 32'h4000, 32'h0, 32'hCAFEF00D, 3);

        for (int i = 0; i < 24; i++) begin
            int k;
            k = $urandom_range(1, 3);
            run_txn(k[0], k[1], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom(), $urandom(), $urandom(), $urandom(), $urandom_range(1, 6));
        end

        // Memory never answers; then memory answers on the last allowed cycle.
        run_txn(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h5000, 32'h0, 32'h55555555, 0);
        run_txn(1'b1, 1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 32'h66666666, 255);

        // Ready while idle must be ignored.
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = 1'b1;
            mem_rd_i    = $urandom();
            @(posedge clk_i);
            @(negedge clk_i);
            check_quiet("idle_ready");
        end
        mem_ready_i = 1'b0;

        // Reset in the middle of BUSY aborts silently.
        ireq_i = 1'b1;
        iaddr_i = 32'h300;
        dreq_i = 1'b1;
        @(posedge clk_i);
        repeat (4) @(negedge clk_i);
        check("abort_busy_mem_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        ireq_i = 1'b0;
        dreq_i = 1'b0;
        model_reset();
        check_quiet("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_quiet("abort_wait");
        end
        run_txn(1'b1, 1'b1, 1'b0, 3'b010, 32'h304, 32'h6000, 32'h0, 32'h77777777, 2);
        run_txn(1'b1, 1'b1, 1'b0, 3'b001, 32'h308, 32'h6004, 32'h0, 32'h88888888, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
